// File: rtl/icache_sa_controller_if.sv
// Bus bundle between the I-cache request controller and its neighbours:
// CPU fetch port, tag/data storage port and single-word memory port.
interface icache_sa_controller_if #(
    parameter int WORD_WIDTH = 32,
    parameter int TAG_BITS   = 24,
    parameter int WAY_BITS   = 1
);
    // CPU fetch side
    logic                  cpu_req;
    logic [31:0]           cpu_addr;
    logic                  cpu_ready;
    logic                  cpu_resp_valid;
    logic [WORD_WIDTH-1:0] cpu_resp_data;

    // Storage array side
    logic                  st_read;
    logic                  st_write;
    logic [31:0]           st_address;
    logic [WORD_WIDTH-1:0] st_write_data;
    logic [TAG_BITS-1:0]   st_write_tag;
    logic [WAY_BITS-1:0]   st_way_select;
    logic                  st_write_valid;
    logic                  st_hit;
    logic [WORD_WIDTH-1:0] st_read_data;

    // Memory side
    logic                  mem_req;
    logic [31:0]           mem_addr;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_data;

    // A request is taken when cpu_req=1 while cpu_ready=1; mem_req is held
    // until a cycle with mem_ack=1; st_hit/st_read_data answer st_read one
    // cycle later.
    modport master (
        input  cpu_req, cpu_addr, st_hit, st_read_data, mem_ack, mem_data,
        output cpu_ready, cpu_resp_valid, cpu_resp_data,
        output st_read, st_write, st_address, st_write_data, st_write_tag,
        output st_way_select, st_write_valid, mem_req, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, st_hit, st_read_data, mem_ack, mem_data,
        input  cpu_ready, cpu_resp_valid, cpu_resp_data,
        input  st_read, st_write, st_address, st_write_data, st_write_tag,
        input  st_way_select, st_write_valid, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_sa_controller.sv
// Request-side controller for a set-associative I-cache: lookup, miss refill
// from a single-word memory port with its own victim choice, and CPU response.
module icache_sa_controller #(
    parameter int WORD_WIDTH    = 32,
    parameter int INDEX_BITS    = 4,
    parameter int TAG_BITS      = 24,
    parameter int ASSOCIATIVITY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    icache_sa_controller_if.master bus,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count,
    output logic [2:0]             state_dbg
);
    localparam int NUM_SETS = 1 << INDEX_BITS;
    localparam int WAY_BITS = $clog2(ASSOCIATIVITY);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_MISS_REQ = 3'd3;
    localparam logic [2:0] S_REFILL   = 3'd4;
    localparam logic [2:0] S_RESPOND  = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [31:0]              addr_q, addr_d;
    logic [WORD_WIDTH-1:0]    resp_data_q, resp_data_d;
    logic [WORD_WIDTH-1:0]    fill_q, fill_d;
    logic [15:0]              hit_q, hit_d;
    logic [15:0]              miss_q, miss_d;
    logic [ASSOCIATIVITY-1:0] valid_q [NUM_SETS];
    logic [ASSOCIATIVITY-1:0] valid_d [NUM_SETS];
    logic [WAY_BITS-1:0]      rr_q [NUM_SETS];
    logic [WAY_BITS-1:0]      rr_d [NUM_SETS];

    logic [INDEX_BITS-1:0]    idx;
    logic [WAY_BITS-1:0]      victim;
    logic                     victim_free;

    assign idx = addr_q[INDEX_BITS-1:0];

    // Lowest empty way wins; the round-robin pointer only matters for a full set.
    always_comb begin
        victim      = rr_q[idx];
        victim_free = 1'b0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (!victim_free && !valid_q[idx][w]) begin
                victim      = WAY_BITS'(w);
                victim_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        resp_data_d = resp_data_q;
        fill_d      = fill_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        valid_d     = valid_q;
        rr_d        = rr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (bus.st_hit) begin
                    resp_data_d = bus.st_read_data;
                    if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
                    state_d = S_RESPOND;
                end else begin
                    if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (bus.mem_ack) begin
                    fill_d      = bus.mem_data;
                    resp_data_d = bus.mem_data;
                    state_d     = S_REFILL;
                end
            end
            S_REFILL: begin
                valid_d[idx][victim] = 1'b1;
                if (!victim_free) rr_d[idx] = rr_q[idx] + WAY_BITS'(1);
                state_d = S_RESPOND;
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            resp_data_q <= '0;
            fill_q      <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            resp_data_q <= resp_data_d;
            fill_q      <= fill_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            valid_q     <= valid_d;
            rr_q        <= rr_d;
        end
    end

    // Strobes are pure state decodes so reset drops them asynchronously.
    assign bus.cpu_ready      = (state_q == S_IDLE);
    assign bus.cpu_resp_valid = (state_q == S_RESPOND);
    assign bus.cpu_resp_data  = resp_data_q;
    assign bus.st_read        = (state_q == S_LOOKUP);
    assign bus.st_write       = (state_q == S_REFILL);
    assign bus.st_write_valid = (state_q == S_REFILL);
    assign bus.st_address     = addr_q;
    assign bus.st_write_data  = fill_q;
    assign bus.st_write_tag   = addr_q[31 -: TAG_BITS];
    assign bus.st_way_select  = victim;
    assign bus.mem_req        = (state_q == S_MISS_REQ);
    assign bus.mem_addr       = addr_q;

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_icache_sa_controller.sv
// Bench for icache_sa_controller: storage and memory models around the DUT,
// directed scenarios plus random traffic checked against a cache-level model.
module tb_icache_sa_controller;
  localparam int WW = 32;
  localparam int TBITS = 24;
  localparam int A = 2;
  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [2:0]  state_dbg;

  icache_sa_controller_if #(.WORD_WIDTH(WW), .TAG_BITS(TBITS), .WAY_BITS(1)) bus();

  icache_sa_controller #(
    .WORD_WIDTH(WW), .INDEX_BITS(4), .TAG_BITS(TBITS), .ASSOCIATIVITY(A)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Storage array model: answers st_read one cycle later, applies st_write.
  logic [TBITS-1:0] sm_tag [NS][A];
  bit               sm_val [NS][A];
  logic [WW-1:0]    sm_data [NS][A];
  bit               pend_hit;
  logic [WW-1:0]    pend_data;
  int               sm_i;

  always @(negedge clk) begin
    if (reset) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < A; w++) sm_val[s][w] = 1'b0;
      pend_hit = 1'b0;
      pend_data = '0;
      bus.st_hit = 1'b0;
      bus.st_read_data = '0;
    end else begin
      bus.st_hit = pend_hit;
      bus.st_read_data = pend_data;
      pend_hit = 1'b0;
      pend_data = $urandom;
      if (bus.st_read) begin
        sm_i = int'(bus.st_address[3:0]);
        for (int w = 0; w < A; w++)
          if (sm_val[sm_i][w] && sm_tag[sm_i][w] == bus.st_address[31:8]) begin
            pend_hit = 1'b1;
            pend_data = sm_data[sm_i][w];
          end
      end
      if (bus.st_write) begin
        sm_i = int'(bus.st_address[3:0]);
        sm_val[sm_i][bus.st_way_select] = 1'b1;
        sm_tag[sm_i][bus.st_way_select] = bus.st_write_tag;
        sm_data[sm_i][bus.st_way_select] = bus.st_write_data;
      end
    end
  end

  // Reference cache model: what each set should hold and which way is next.
  logic [TBITS-1:0] rm_tag [NS][A];
  bit               rm_val [NS][A];
  logic [WW-1:0]    rm_data [NS][A];
  int               rm_rr [NS];
  int               exp_hits;
  int               exp_misses;

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      rm_rr[s] = 0;
      for (int w = 0; w < A; w++) rm_val[s][w] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One fetch from accept to return-to-idle, checked cycle by cycle.
  task automatic txn(input logic [31:0] a, input int d, input bit hold_ack,
                     input bit toggle, input logic [31:0] mword,
                     output bit got_miss, output int got_way);
    int set, hitway, way, n;
    bit hit;
    set = int'(a[3:0]);
    hit = 1'b0;
    hitway = 0;
    got_way = -1;
    for (int w = 0; w < A; w++)
      if (rm_val[set][w] && rm_tag[set][w] == a[31:8]) begin
        hit = 1'b1;
        hitway = w;
      end
    n = 0;
    while (!bus.cpu_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", bus.cpu_ready, 1);
    if (hold_ack) begin
      bus.mem_ack = 1'b1;
      bus.mem_data = mword;
    end else begin
      bus.mem_data = $urandom;
    end
    bus.cpu_req = 1'b1;
    bus.cpu_addr = a;
    @(negedge clk);  // LOOKUP
    bus.cpu_req = toggle;
    if (toggle) bus.cpu_addr = a ^ 32'hFFFF_00F0;
    chk("lookup_st_read", bus.st_read, 1);
    chk("lookup_st_address", bus.st_address, a);
    chk("lookup_not_ready", bus.cpu_ready, 0);
    @(negedge clk);  // CHECK
    if (toggle) begin
      bus.cpu_req = 1'b0;
      bus.cpu_addr = $urandom;
    end
    chk("check_quiet", {28'd0, bus.st_read, bus.st_write, bus.mem_req, bus.cpu_resp_valid}, 0);
    @(negedge clk);  // k+3
    got_miss = bus.mem_req;
    if (hit) begin
      bus.cpu_req = 1'b0;
      exp_hits++;
      chk("hit_resp_valid", bus.cpu_resp_valid, 1);
      chk("hit_resp_data", bus.cpu_resp_data, rm_data[set][hitway]);
      chk("hit_no_mem_req", bus.mem_req, 0);
      chk("hit_count", hit_count, exp_hits[15:0]);
    end else begin
      exp_misses++;
      chk("miss_mem_req", bus.mem_req, 1);
      chk("miss_mem_addr", bus.mem_addr, a);
      chk("miss_no_resp", bus.cpu_resp_valid, 0);
      chk("miss_count", miss_count, exp_misses[15:0]);
      way = -1;
      for (int w = 0; w < A; w++)
        if (way < 0 && !rm_val[set][w]) way = w;
      if (way < 0) begin
        way = rm_rr[set];
        rm_rr[set] = (rm_rr[set] + 1) % A;
      end
      if (!hold_ack) begin
        repeat (d) begin
          if (toggle) begin
            bus.cpu_req = ~bus.cpu_req;
            bus.cpu_addr = $urandom;
          end
          @(negedge clk);
          chk("mem_req_held", bus.mem_req, 1);
          chk("mem_addr_held", bus.mem_addr, a);
        end
        bus.mem_ack = 1'b1;
        bus.mem_data = mword;
      end
      @(negedge clk);  // REFILL
      bus.cpu_req = 1'b0;
      if (hold_ack) bus.mem_data = ~mword;
      else begin
        bus.mem_ack = 1'b0;
        bus.mem_data = $urandom;
      end
      got_way = int'(bus.st_way_select);
      chk("refill_st_write", bus.st_write, 1);
      chk("refill_valid_bit", bus.st_write_valid, 1);
      chk("refill_address", bus.st_address, a);
      chk("refill_tag", {8'd0, bus.st_write_tag}, {8'd0, a[31:8]});
      chk("refill_way", got_way, way);
      chk("refill_data", bus.st_write_data, mword);
      chk("refill_no_mem_req", bus.mem_req, 0);
      rm_val[set][way] = 1'b1;
      rm_tag[set][way] = a[31:8];
      rm_data[set][way] = mword;
      @(negedge clk);  // RESPOND
      chk("miss_resp_valid", bus.cpu_resp_valid, 1);
      chk("miss_resp_data", bus.cpu_resp_data, mword);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("back_idle_ready", bus.cpu_ready, 1);
    chk("back_idle_no_resp", bus.cpu_resp_valid, 0);
  endtask

  logic [23:0] tag_pool [3];
  logic [31:0] ra;
  bit          miss_o;
  int          way_o;
  int          exp_ways [4];

  initial begin
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;
    model_clear();
    @(negedge clk);
    chk("rst_ready", bus.cpu_ready, 1);
    chk("rst_strobes", {28'd0, bus.st_read, bus.st_write, bus.mem_req, bus.cpu_resp_valid}, 0);
    chk("rst_resp_data", bus.cpu_resp_data, 0);
    chk("rst_address", bus.st_address, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    chk("rst_state", {29'd0, state_dbg}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Cold miss then hit on the same line
    txn(32'h1234_5678, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, miss_o, way_o);
    chk("cold_is_miss", miss_o, 1);
    chk("cold_way0", way_o, 0);
    chk("cold_miss_count", miss_count, 1);
    txn(32'h1234_5678, 0, 1'b0, 1'b0, 32'h0, miss_o, way_o);
    chk("repeat_is_hit", miss_o, 0);
    chk("repeat_hit_count", hit_count, 1);

    // Conflict set 8 from an empty cache
    do_reset();
    exp_ways = '{0, 1, 0, 1};
    txn(32'hAAAA_AA08, 1, 1'b0, 1'b0, 32'h0A0A_0A0A, miss_o, way_o);
    chk("conflict_way_a", way_o, exp_ways[0]);
    txn(32'hBBBB_BB08, 2, 1'b0, 1'b0, 32'h0B0B_0B0B, miss_o, way_o);
    chk("conflict_way_b", way_o, exp_ways[1]);
    txn(32'hCCCC_CC08, 0, 1'b0, 1'b0, 32'h0C0C_0C0C, miss_o, way_o);
    chk("conflict_way_c", way_o, exp_ways[2]);
    txn(32'hDDDD_DD08, 4, 1'b0, 1'b0, 32'h0D0D_0D0D, miss_o, way_o);
    chk("conflict_way_d", way_o, exp_ways[3]);
    txn(32'hAAAA_AA08, 1, 1'b0, 1'b0, 32'h1A1A_1A1A, miss_o, way_o);
    chk("evicted_a_misses", miss_o, 1);

    // Ack held high from before the miss, then a hit with ack still high
    txn(32'h0000_4563, 0, 1'b1, 1'b0, 32'hCAFE_F00D, miss_o, way_o);
    chk("imm_ack_miss", miss_o, 1);
    txn(32'h0000_4563, 0, 1'b1, 1'b0, 32'h5555_AAAA, miss_o, way_o);
    chk("imm_ack_hit", miss_o, 0);

    // Request line toggled with other addresses during a miss
    txn(32'h7777_7701, 3, 1'b0, 1'b1, 32'h1357_9BDF, miss_o, way_o);
    chk("hold_miss", miss_o, 1);

    // Reset while mem_req is up
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h9999_9902;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_mem_req", bus.mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_req_drop", bus.mem_req, 0);
    chk("async_ready", bus.cpu_ready, 1);
    chk("async_resp_valid", bus.cpu_resp_valid, 0);
    chk("async_resp_data", bus.cpu_resp_data, 0);
    chk("async_address", bus.mem_addr, 0);
    chk("async_counts", {hit_count, miss_count}, 0);
    repeat (2) @(negedge clk);
    model_clear();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_resp", bus.cpu_resp_valid, 0);
    end
    txn(32'h9999_9902, 1, 1'b0, 1'b0, 32'h2468_ACE0, miss_o, way_o);
    chk("after_reset_misses", miss_o, 1);

    // Random traffic over a few sets and a small tag pool
    for (int i = 0; i < 3; i++) tag_pool[i] = 24'($urandom);
    for (int i = 0; i < 150; i++) begin
      ra = {tag_pool[$urandom_range(0, 2)], 4'($urandom), 4'($urandom_range(0, 2))};
      txn(ra, $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
          $urandom, miss_o, way_o);
    end
    chk("final_hit_count", hit_count, exp_hits[15:0]);
    chk("final_miss_count", miss_count, exp_misses[15:0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
